mfcc_frame_sequencer: RTL and testbench

MFCC_FRAME_SEQUENCER -- requirements
Module: mfcc_frame_sequencer

---
 rtl/mfcc_pkg.sv | 27 ++
 rtl/mfcc_frame_sequencer_ceps_buffer.sv | 44 ++++
 rtl/mfcc_frame_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_mfcc_frame_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfcc_pkg.sv
//------------------------------------------------------------------------------
// Module      : mfcc_pkg
// Description : Shared definitions for the MFCC frame sequencer: sequencer
//               state encoding, datapath width and fixed-point formats.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mfcc_pkg;

  // Sample / coefficient word width
  localparam int DATA_W = 16;
  // Fractional bits of the log-mel input samples (Q11)
  localparam int Q_L    = 11;
  // Fractional bits of the DCT output coefficients (Q4)
  localparam int Q_D    = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_EMIT    = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/mfcc_frame_sequencer_ceps_buffer.sv
//------------------------------------------------------------------------------
// Module      : ceps_buffer
// Description : NUM_CEPS x DATA_W register file holding the kept cepstral
//               coefficients of one frame. One write port, one combinational
//               read port, and a flag marking the final read slot.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ceps_buffer
  import mfcc_pkg::*;
#(
  parameter int NUM_CEPS = 13,
  parameter int IDX_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_last
);

  logic [DATA_W-1:0] r_mem [NUM_CEPS];

  // Coefficient storage; cleared on reset so stale data never leaks out
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CEPS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_idx];
  assign o_last    = (i_rd_idx == IDX_W'(NUM_CEPS - 1));

endmodule

`default_nettype wire

// File: rtl/mfcc_frame_sequencer.sv
//------------------------------------------------------------------------------
// Module      : mfcc_frame_sequencer
// Description : Feeds N log-mel samples per frame to a DCT core, collects the
//               N result strobes, keeps NUM_CEPS coefficients and streams them
//               downstream with valid/ready. A watchdog aborts a frame whose
//               DCT results do not arrive within WAIT_MAX cycles.
// Config      : MFCC_SEQ_DROP_C0_EN - discard C0 and keep C1..C(NUM_CEPS)
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mfcc_frame_sequencer
  import mfcc_pkg::*;
#(
  parameter int N        = 32,
  parameter int NUM_CEPS = 13,
  parameter int WAIT_MAX = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] logmel_in,
  input  logic              logmel_valid,
  output logic              logmel_ready,
  output logic [DATA_W-1:0] dct_data_in,
  output logic              dct_data_valid,
  input  logic [DATA_W-1:0] dct_result,
  input  logic              dct_result_valid,
  output logic [DATA_W-1:0] mfcc_out,
  output logic              mfcc_valid,
  input  logic              mfcc_ready,
  output logic              mfcc_last,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       frame_count
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int RW = (NUM_CEPS > 1) ? $clog2(NUM_CEPS) : 1;
  localparam int WW = $clog2(WAIT_MAX + 1);

  seq_state_t        r_state;
  seq_state_t        w_next;
  logic [CW-1:0]     r_sample_cnt;
  logic [CW-1:0]     r_k;
  logic [WW-1:0]     r_wd;
  logic [RW-1:0]     r_rd_idx;
  logic [RW-1:0]     w_wr_idx;
  logic [DATA_W-1:0] r_dct_data;
  logic              r_dct_valid;
  logic              r_timeout;
  logic [15:0]       r_frame_count;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_rd_last;
  logic [31:0]       w_k32;
  logic              w_accept;
  logic              w_strobe;
  logic              w_keep;
  logic              w_last_sample;
  logic              w_last_k;
  logic              w_wd_expire;
  logic              w_handshake;

  assign w_accept      = (r_state == ST_LOAD) && logmel_valid;
  assign w_strobe      = (r_state == ST_COLLECT) && dct_result_valid;
  assign w_last_sample = (r_sample_cnt == CW'(N - 1));
  assign w_last_k      = (r_k == CW'(N - 1));
  assign w_wd_expire   = (r_wd == WW'(WAIT_MAX - 1));
  assign w_handshake   = (r_state == ST_EMIT) && mfcc_ready;
  assign w_k32         = 32'(r_k);

`ifdef MFCC_SEQ_DROP_C0_EN
  // C0 carries frame energy and is dropped; slot j holds coefficient j+1
  assign w_keep   = w_strobe && (w_k32 >= 32'd1) && (w_k32 <= 32'(NUM_CEPS));
  assign w_wr_idx = RW'(w_k32 - 32'd1);
`else
  assign w_keep   = w_strobe && (w_k32 < 32'(NUM_CEPS));
  assign w_wr_idx = RW'(w_k32);
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; a final DCT strobe wins over a same-cycle watchdog expiry
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    w_next = ST_LOAD;
      ST_LOAD:    if (w_accept && w_last_sample) w_next = ST_COLLECT;
      ST_COLLECT: begin
        if (w_strobe && w_last_k) begin
          w_next = ST_EMIT;
        end else if (w_wd_expire) begin
          w_next = ST_IDLE;
        end
      end
      ST_EMIT:    if (w_handshake && w_rd_last) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Counters, DCT input register, watchdog and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sample_cnt  <= '0;
      r_k           <= '0;
      r_wd          <= '0;
      r_rd_idx      <= '0;
      r_dct_data    <= '0;
      r_dct_valid   <= 1'b0;
      r_timeout     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      // Upstream gaps propagate as gaps: valid only follows an accepted sample
      r_dct_valid <= w_accept;
      if (w_accept) begin
        r_dct_data <= logmel_in;
      end
      case (r_state)
        ST_IDLE: begin
          r_sample_cnt <= '0;
          r_k          <= '0;
          r_rd_idx     <= '0;
          r_wd         <= '0;
        end
        ST_LOAD: begin
          if (w_accept) begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
            if (w_last_sample) begin
              r_wd <= '0;
            end
          end
        end
        ST_COLLECT: begin
          r_wd <= r_wd + 1'b1;
          if (w_strobe) begin
            r_k <= r_k + 1'b1;
          end
          if (w_wd_expire && !(w_strobe && w_last_k)) begin
            r_timeout <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (w_handshake) begin
            r_rd_idx <= r_rd_idx + 1'b1;
            if (w_rd_last) begin
              r_frame_count <= r_frame_count + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  ceps_buffer #(
    .NUM_CEPS (NUM_CEPS),
    .IDX_W    (RW)
  ) u_ceps_buffer (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_keep),
    .i_wr_idx  (w_wr_idx),
    .i_wr_data (dct_result),
    .i_rd_idx  (r_rd_idx),
    .o_rd_data (w_rd_data),
    .o_last    (w_rd_last)
  );

  assign logmel_ready   = (r_state == ST_LOAD);
  assign dct_data_in    = r_dct_data;
  assign dct_data_valid = r_dct_valid;
  assign mfcc_valid     = (r_state == ST_EMIT);
  assign mfcc_out       = mfcc_valid ? w_rd_data : '0;
  assign mfcc_last      = mfcc_valid && w_rd_last;
  assign busy           = (r_state != ST_IDLE);
  assign timeout_err    = r_timeout;
  assign frame_count    = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_mfcc_frame_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_mfcc_frame_sequencer
// Description : Self-checking bench for mfcc_frame_sequencer. Frame scenarios
//               come from a vector table; a monitor checks sample latency,
//               hold stability and records strobes for frame-level checks.
// Config      : MFCC_SEQ_DROP_C0_EN - expected coefficients shift by one
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mfcc_frame_sequencer;

  localparam int N  = 32;
  localparam int NC = 13;
  localparam int WM = 2048;
`ifdef MFCC_SEQ_DROP_C0_EN
  localparam logic [15:0] OFF = 16'd1;
`else
  localparam logic [15:0] OFF = 16'd0;
`endif

  typedef struct {
    int          vp;        // upstream valid probability %, -1 = 1010 pattern
    int          rp;        // DCT strobe probability %
    int          rdyp;      // downstream ready probability %
    logic [15:0] sbase;     // sample i carries sbase+i
    logic [15:0] rbase;     // coefficient k carries rbase+k
    int          stall_at;  // outputs taken before forced stall, -1 = none
    int          stall_len;
    bit          noise;     // stray DCT strobes outside COLLECT
    int          exp_count;
    logic [15:0] exp_first;
    logic [15:0] exp_lastv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] logmel_in = '0;
  logic        logmel_valid = 1'b0;
  logic        logmel_ready;
  logic [15:0] dct_data_in;
  logic        dct_data_valid;
  logic [15:0] dct_result = '0;
  logic        dct_result_valid = 1'b0;
  logic [15:0] mfcc_out;
  logic        mfcc_valid;
  logic        mfcc_ready = 1'b0;
  logic        mfcc_last;
  logic        busy;
  logic        timeout_err;
  logic [15:0] frame_count;

  int          total = 0;
  int          bad = 0;
  int          exp_fc = 0;
  logic [15:0] q_dct[$];
  logic [16:0] q_out[$];
  logic        acc_pend = 1'b0;
  logic        hold_pend = 1'b0;
  logic [15:0] acc_val = '0;
  logic [15:0] hold_val = '0;
  vec_t        vecs[5];

  mfcc_frame_sequencer #(
    .N        (N),
    .NUM_CEPS (NC),
    .WAIT_MAX (WM)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .logmel_in        (logmel_in),
    .logmel_valid     (logmel_valid),
    .logmel_ready     (logmel_ready),
    .dct_data_in      (dct_data_in),
    .dct_data_valid   (dct_data_valid),
    .dct_result       (dct_result),
    .dct_result_valid (dct_result_valid),
    .mfcc_out         (mfcc_out),
    .mfcc_valid       (mfcc_valid),
    .mfcc_ready       (mfcc_ready),
    .mfcc_last        (mfcc_last),
    .busy             (busy),
    .timeout_err      (timeout_err),
    .frame_count      (frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: an accepted sample must appear on the DCT port exactly one cycle
  // later and nothing else may; a stalled output must hold value and valid.
  always @(negedge clk) begin
    if (rst) begin
      acc_pend  = 1'b0;
      hold_pend = 1'b0;
    end else begin
      chk("dct_valid_latency", 32'(dct_data_valid), 32'(acc_pend));
      if (acc_pend) chk("dct_data_pass", 32'(dct_data_in), 32'(acc_val));
      if (dct_data_valid) q_dct.push_back(dct_data_in);
      if (hold_pend) begin
        chk("hold_valid", 32'(mfcc_valid), 32'd1);
        chk("hold_data", 32'(mfcc_out), 32'(hold_val));
      end
      if (mfcc_valid && mfcc_ready) q_out.push_back({mfcc_last, mfcc_out});
      acc_pend  = logmel_valid && logmel_ready;
      acc_val   = logmel_in;
      hold_pend = mfcc_valid && !mfcc_ready;
      hold_val  = mfcc_out;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_logmel_ready"}, 32'(logmel_ready), 32'd0);
    chk({tag, "_dct_data_in"}, 32'(dct_data_in), 32'd0);
    chk({tag, "_dct_data_valid"}, 32'(dct_data_valid), 32'd0);
    chk({tag, "_mfcc_out"}, 32'(mfcc_out), 32'd0);
    chk({tag, "_mfcc_valid"}, 32'(mfcc_valid), 32'd0);
    chk({tag, "_mfcc_last"}, 32'(mfcc_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
  endtask

  // Offer N samples (sbase+i) upstream; returns one cycle after the last accept
  task automatic load_frame(input int vp, input logic [15:0] sbase, input bit noise);
    int idx = 0;
    int cyc = 0;
    bit tog = 1'b1;
    while (idx < N && cyc < 1000) begin
      step();
      cyc++;
      logmel_valid = (vp < 0) ? tog : ($urandom_range(0, 99) < vp);
      tog          = ~tog;
      logmel_in    = sbase + 16'(idx);
      if (noise) begin
        dct_result_valid = 1'($urandom_range(0, 1));
        dct_result       = 16'hDEAD;
      end
      if (logmel_valid && logmel_ready) idx++;
    end
    step();
    logmel_valid     = 1'b0;
    dct_result_valid = 1'b0;
    chk("load_accepted", 32'(idx), 32'(N));
  endtask

  // Send `count` DCT results rbase+k with random gaps
  task automatic collect(input int rp, input logic [15:0] rbase, input int count);
    int k = 0;
    int cyc = 0;
    while (k < count && cyc < 1000) begin
      dct_result_valid = ($urandom_range(0, 99) < rp);
      dct_result       = rbase + 16'(k);
      if (dct_result_valid) k++;
      step();
      cyc++;
    end
    dct_result_valid = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string tag);
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    int n;
    q_dct.delete();
    q_out.delete();
    mfcc_ready = 1'b0;
    load_frame(v.vp, v.sbase, v.noise);
    collect(v.rp, v.rbase, N);
    while (q_out.size() < v.exp_count && cyc < 3000) begin
      step();
      cyc++;
      if (v.noise) begin
        dct_result_valid = 1'($urandom_range(0, 1));
        dct_result       = 16'hBAD0;
      end
      if (!stalled && v.stall_at >= 0 && q_out.size() == v.stall_at && mfcc_valid) begin
        stalled    = 1'b1;
        stall_left = v.stall_len;
      end
      if (stall_left > 0) begin
        mfcc_ready = 1'b0;
        stall_left--;
      end else begin
        mfcc_ready = ($urandom_range(0, 99) < v.rdyp);
      end
      @(negedge clk);
      #1;
    end
    step();
    dct_result_valid = 1'b0;
    mfcc_ready       = 1'b0;
    exp_fc++;
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(exp_fc));
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_valid"}, 32'(mfcc_valid), 32'd0);
    step();
    chk({tag, "_turnaround_ready"}, 32'(logmel_ready), 32'd1);
    chk({tag, "_dct_strobes"}, 32'(q_dct.size()), 32'(N));
    n = (q_dct.size() < N) ? q_dct.size() : N;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_dct_sample%0d", tag, i), 32'(q_dct[i]), 32'(v.sbase + 16'(i)));
    end
    chk({tag, "_out_count"}, 32'(q_out.size()), 32'(v.exp_count));
    for (int j = 0; j < q_out.size(); j++) begin
      chk($sformatf("%s_coef%0d", tag, j), 32'(q_out[j][15:0]), 32'(v.exp_first + 16'(j)));
      chk($sformatf("%s_last%0d", tag, j), 32'(q_out[j][16]), 32'(j == v.exp_count - 1));
    end
    if (q_out.size() > 0) begin
      chk({tag, "_final_value"}, 32'(q_out[q_out.size() - 1][15:0]), 32'(v.exp_lastv));
    end
  endtask

  initial begin
    vecs[0] = '{100, 100, 100, 16'h0000, 16'd100, -1, 0, 1'b0, NC, 16'd100 + OFF, 16'd112 + OFF};
    vecs[1] = '{-1, 100, 100, 16'h0100, 16'h0200, -1, 0, 1'b0, NC, 16'h0200 + OFF, 16'h020C + OFF};
    vecs[2] = '{100, 100, 100, 16'h0040, 16'd300, 2, 10, 1'b0, NC, 16'd300 + OFF, 16'd312 + OFF};
    vecs[3] = '{60, 50, 50, 16'h8000, 16'hFF00, -1, 0, 1'b1, NC, 16'hFF00 + OFF, 16'hFF0C + OFF};
    vecs[4] = '{30, 70, 30, 16'h7FF0, 16'h7FE0, 12, 5, 1'b1, NC, 16'h7FE0 + OFF, 16'h7FEC + OFF};

    // Reset with busy inputs: everything must sit at its reset value
    rst              = 1'b1;
    logmel_valid     = 1'b1;
    dct_result_valid = 1'b1;
    mfcc_ready       = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    logmel_valid     = 1'b0;
    dct_result_valid = 1'b0;
    mfcc_ready       = 1'b0;
    rst              = 1'b0;

    for (int t = 0; t < 5; t++) begin
      run_frame(vecs[t], $sformatf("vec%0d", t));
    end

    // Watchdog: 3 partial results, then silence until expiry
    q_out.delete();
    load_frame(100, 16'h0500, 1'b0);
    collect(100, 16'd900, 3);
    repeat (WM - 1 - 3) step();
    chk("wd_not_yet", 32'(timeout_err), 32'd0);
    chk("wd_still_busy", 32'(busy), 32'd1);
    step();
    chk("wd_timeout_set", 32'(timeout_err), 32'd1);
    chk("wd_idle", 32'(busy), 32'd0);
    chk("wd_no_valid", 32'(mfcc_valid), 32'd0);
    chk("wd_no_outputs", 32'(q_out.size()), 32'd0);
    run_frame(vecs[0], "after_wd");
    chk("wd_sticky", 32'(timeout_err), 32'd1);

    // Reset in COLLECT at k=5 with strobes still arriving
    load_frame(100, 16'h0600, 1'b0);
    collect(100, 16'd700, 5);
    rst              = 1'b1;
    dct_result_valid = 1'b1;
    dct_result       = 16'hBEEF;
    logmel_valid     = 1'b1;
    mfcc_ready       = 1'b1;
    step();
    step();
    check_reset_outputs("midrst");
    rst              = 1'b0;
    dct_result_valid = 1'b0;
    logmel_valid     = 1'b0;
    mfcc_ready       = 1'b0;
    exp_fc           = 0;
    run_frame(vecs[2], "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
